// File: rtl/mmult_loader.sv
// Producer-side front end for the 3x3 matrix multiplier: packs an 18-byte stream
// into A_mat/B_mat, runs the multiplier and reports completion or timeout.
module mmult_loader #(
   parameter int N_ELEM  = 9,
   parameter int ELEM_W  = 8,
   parameter int TIMEOUT = 16
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       start,
   input  logic [ELEM_W-1:0]          in_data,
   input  logic                       in_valid,
   output logic                       in_ready,
   output logic [0:N_ELEM*ELEM_W-1]   A_mat,
   output logic [0:N_ELEM*ELEM_W-1]   B_mat,
   output logic                       mm_enable,
   input  logic                       mm_valid,
   output logic                       busy,
   output logic                       done,
   output logic                       err
);

   localparam logic [4:0] LAST_BYTE = 5'(2*N_ELEM-1);
   localparam logic [4:0] B_BASE    = 5'(N_ELEM);
   localparam logic [7:0] TMO_LAST  = 8'(TIMEOUT-1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_RUN,
      S_DONE,
      S_ERR
   } state_t;

   state_t     state, state_nx;
   logic [4:0] byte_cnt, byte_cnt_nx;
   logic [7:0] tmo_cnt, tmo_cnt_nx;
   logic       byte_we;

   // Decoded from state only, so there is no combinational path from in_valid.
   assign in_ready = (state == S_LOAD);

   always_comb begin
      state_nx    = state;
      byte_cnt_nx = byte_cnt;
      tmo_cnt_nx  = tmo_cnt;
      byte_we     = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) begin
               state_nx    = S_LOAD;
               byte_cnt_nx = '0;
            end
         end
         S_LOAD: begin
            if (in_valid) begin
               byte_we     = 1'b1;
               byte_cnt_nx = byte_cnt + 5'd1;
               if (byte_cnt == LAST_BYTE) begin
                  state_nx   = S_RUN;
                  tmo_cnt_nx = '0;
               end
            end
         end
         S_RUN: begin
            // A response arriving on the expiry edge still counts as success.
            if (mm_valid) begin
               state_nx = S_DONE;
            end else if (tmo_cnt == TMO_LAST) begin
               state_nx = S_ERR;
            end else begin
               tmo_cnt_nx = tmo_cnt + 8'd1;
            end
         end
         S_DONE:  state_nx = S_IDLE;
         S_ERR:   state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   // Status outputs are registered from the next state so they line up with it.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= S_IDLE;
         byte_cnt  <= '0;
         tmo_cnt   <= '0;
         busy      <= 1'b0;
         mm_enable <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
      end else begin
         state     <= state_nx;
         byte_cnt  <= byte_cnt_nx;
         tmo_cnt   <= tmo_cnt_nx;
         busy      <= (state_nx != S_IDLE);
         mm_enable <= (state_nx == S_RUN);
         done      <= (state_nx == S_DONE);
         err       <= (state_nx == S_ERR);
      end
   end

   // Byte k of the stream lands in A element k, then B element k-N_ELEM.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         A_mat <= '0;
         B_mat <= '0;
      end else if (byte_we) begin
         for (int k = 0; k < N_ELEM; k++) begin
            if (byte_cnt == 5'(k)) begin
               A_mat[k*ELEM_W +: ELEM_W] <= in_data;
            end
            if (byte_cnt == B_BASE + 5'(k)) begin
               B_mat[k*ELEM_W +: ELEM_W] <= in_data;
            end
         end
      end
   end

endmodule

// File: tb/tb_mmult_loader.sv
// Bench for mmult_loader: drives byte streams, emulates the 3x3 multiplier and
// compares operands, products and done/err timing against a behavioural model.
module tb_mmult_loader;

   localparam int N_ELEM  = 9;
   localparam int ELEM_W  = 8;
   localparam int TIMEOUT = 16;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic        in_valid = 1'b0;
   logic        mm_valid = 1'b0;
   logic [7:0]  in_data = 8'h00;
   logic        in_ready, mm_enable, busy, done, err;
   logic [0:71] A_mat, B_mat;

   int          total = 0;
   int          bad = 0;
   logic [7:0]  ref_bytes [18];
   int          resp_edges = 0;
   int          en_cnt = 0;
   int          acc_cnt = 0;
   logic [7:0]  c_mat [9];

   mmult_loader #(.N_ELEM(N_ELEM), .ELEM_W(ELEM_W), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .reset(reset), .start(start), .in_data(in_data),
      .in_valid(in_valid), .in_ready(in_ready), .A_mat(A_mat), .B_mat(B_mat),
      .mm_enable(mm_enable), .mm_valid(mm_valid), .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] elem(input logic [0:71] m, input int k);
      return m[k*8 +: 8];
   endfunction

   // Multiplier stand-in: loader sees mm_valid resp_edges edges after RUN entry (0 = never).
   always @(posedge clk) begin
      if (in_valid && in_ready) acc_cnt <= acc_cnt + 1;
      if (!mm_enable) begin
         en_cnt   <= 0;
         mm_valid <= 1'b0;
      end else begin
         en_cnt <= en_cnt + 1;
         if (resp_edges != 0 && en_cnt + 2 >= resp_edges) begin
            mm_valid <= 1'b1;
            for (int i = 0; i < 3; i++)
               for (int j = 0; j < 3; j++)
                  c_mat[i*3+j] <= 8'(elem(A_mat, i*3) * elem(B_mat, j)
                                   + elem(A_mat, i*3+1) * elem(B_mat, 3+j)
                                   + elem(A_mat, i*3+2) * elem(B_mat, 6+j));
         end
      end
   end

   function automatic logic [71:0] ref_mat(input int base);
      logic [71:0] m = '0;
      for (int k = 0; k < 9; k++) m = {m[63:0], ref_bytes[base+k]};
      return m;
   endfunction

   function automatic logic [7:0] ref_c(input int idx);
      int s = 0;
      for (int k = 0; k < 3; k++) s += ref_bytes[(idx/3)*3+k] * ref_bytes[9+k*3+(idx%3)];
      return 8'(s);
   endfunction

   task automatic do_start();
      @(negedge clk); start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
   endtask

   // stall_pct < 0 selects the fixed 1,0,0,1 valid pattern.
   task automatic drive_bytes(input int n, input int stall_pct, output int cycles, output int drops);
      int  idx = 0;
      bit  v;
      cycles = 0;
      drops  = 0;
      while (idx < n && cycles < 1000) begin
         @(negedge clk);
         cycles++;
         if (!in_ready) drops++;
         if (stall_pct < 0) v = ((cycles-1) % 4 == 0) || ((cycles-1) % 4 == 3);
         else v = ($urandom_range(99) >= stall_pct);
         in_valid = v;
         if (v) begin
            in_data = ref_bytes[idx];
            if (in_ready) idx++;
         end else begin
            in_data = 8'($urandom);
         end
      end
   endtask

   task automatic wait_outcome(input bit junk, input bit start_in_run, input bit start_in_done,
                               output int k_done, output int k_err, output bit en_ok,
                               output bit en_end, output bit post_idle);
      @(posedge clk); #1;
      en_ok  = mm_enable;
      en_end = 1'b1;
      k_done = -1;
      k_err  = -1;
      in_valid = junk;
      in_data  = 8'($urandom);
      if (start_in_run) start = 1'b1;
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk); #1;
         if (k == 2 && start_in_run) start = 1'b0;
         if (junk) in_data = 8'($urandom);
         if (done || err) begin
            if (done) k_done = k;
            if (err) k_err = k;
            en_end = mm_enable;
            break;
         end
         if (!mm_enable) en_ok = 1'b0;
      end
      if (start_in_done) start = 1'b1;
      @(posedge clk); #1;
      if (start_in_done) start = 1'b0;
      post_idle = !busy && !done && !err;
      in_valid  = 1'b0;
   endtask

   task automatic test_reset();
      #1 reset = 1'b1;
      #12;
      total++; if (in_ready !== 1'b0) begin bad++; $display("[TB] FAIL reset_in_ready: got %b want 0", in_ready); end
      total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
      total++; if (mm_enable !== 1'b0) begin bad++; $display("[TB] FAIL reset_enable: got %b want 0", mm_enable); end
      total++; if ({done, err} !== 2'b00) begin bad++; $display("[TB] FAIL reset_done_err: got %b want 00", {done, err}); end
      total++; if (A_mat !== 72'h0) begin bad++; $display("[TB] FAIL reset_A: got %h want 0", A_mat); end
      total++; if (B_mat !== 72'h0) begin bad++; $display("[TB] FAIL reset_B: got %h want 0", B_mat); end
      @(negedge clk); reset = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL idle_no_start_busy: got %b want 0", busy); end
   endtask

   task automatic test_identity();
      int cyc, drops, kd, ke, base;
      bit en_ok, en_end, post_idle;
      for (int k = 0; k < 9; k++) ref_bytes[k] = 8'(k+1);
      for (int k = 0; k < 9; k++) ref_bytes[9+k] = (k % 4 == 0) ? 8'd1 : 8'd0;
      resp_edges = 2;
      base = acc_cnt;
      do_start();
      drive_bytes(18, 0, cyc, drops);
      wait_outcome(1'b1, 1'b0, 1'b0, kd, ke, en_ok, en_end, post_idle);
      total++; if (A_mat !== 72'h010203040506070809) begin bad++; $display("[TB] FAIL ident_A: got %h want 010203040506070809", A_mat); end
      total++; if (B_mat !== ref_mat(9)) begin bad++; $display("[TB] FAIL ident_B: got %h want %h", B_mat, ref_mat(9)); end
      total++; if (kd !== 2 || ke !== -1) begin bad++; $display("[TB] FAIL ident_outcome: got done@%0d err@%0d want done@2 err@-1", kd, ke); end
      // Start edge counts as edge 1; done becomes visible after edge 21.
      total++; if (1 + cyc + kd !== 21) begin bad++; $display("[TB] FAIL ident_latency: got edge %0d want 21", 1 + cyc + kd); end
      total++; if (!en_ok || en_end) begin bad++; $display("[TB] FAIL ident_enable: got run=%b at_done=%b want 1/0", en_ok, en_end); end
      total++; if (!post_idle) begin bad++; $display("[TB] FAIL ident_pulse: got not idle after done, want idle"); end
      total++; if (acc_cnt - base !== 18) begin bad++; $display("[TB] FAIL ident_accepts: got %0d want 18", acc_cnt - base); end
      for (int i = 0; i < 9; i++) begin
         total++; if (c_mat[i] !== 8'(i+1)) begin bad++; $display("[TB] FAIL ident_C%0d: got %0d want %0d", i, c_mat[i], i+1); end
      end
   endtask

   task automatic test_stall();
      int cyc, drops, kd, ke, base;
      bit en_ok, en_end, post_idle;
      resp_edges = 4;
      base = acc_cnt;
      do_start();
      drive_bytes(18, -1, cyc, drops);
      wait_outcome(1'b0, 1'b0, 1'b0, kd, ke, en_ok, en_end, post_idle);
      total++; if (drops !== 0) begin bad++; $display("[TB] FAIL stall_ready: got %0d low cycles want 0", drops); end
      total++; if (acc_cnt - base !== 18) begin bad++; $display("[TB] FAIL stall_accepts: got %0d want 18", acc_cnt - base); end
      total++; if (A_mat !== ref_mat(0)) begin bad++; $display("[TB] FAIL stall_A: got %h want %h", A_mat, ref_mat(0)); end
      total++; if (B_mat !== ref_mat(9)) begin bad++; $display("[TB] FAIL stall_B: got %h want %h", B_mat, ref_mat(9)); end
      total++; if (kd !== 4 || ke !== -1) begin bad++; $display("[TB] FAIL stall_outcome: got done@%0d err@%0d want done@4", kd, ke); end
   endtask

   task automatic test_timeout();
      int cyc, drops, kd, ke;
      bit en_ok, en_end, post_idle;
      for (int k = 0; k < 18; k++) ref_bytes[k] = 8'($urandom);
      resp_edges = 0;
      do_start();
      drive_bytes(18, 20, cyc, drops);
      wait_outcome(1'b0, 1'b0, 1'b0, kd, ke, en_ok, en_end, post_idle);
      total++; if (ke !== TIMEOUT || kd !== -1) begin bad++; $display("[TB] FAIL timeout_outcome: got err@%0d done@%0d want err@%0d", ke, kd, TIMEOUT); end
      total++; if (!en_ok || en_end) begin bad++; $display("[TB] FAIL timeout_enable: got run=%b at_err=%b want 1/0", en_ok, en_end); end
      total++; if (!post_idle) begin bad++; $display("[TB] FAIL timeout_idle: got busy=%b err=%b want idle", busy, err); end
   endtask

   task automatic test_priority();
      int cyc, drops, kd, ke;
      bit en_ok, en_end, post_idle;
      resp_edges = TIMEOUT;
      do_start();
      drive_bytes(18, 0, cyc, drops);
      wait_outcome(1'b0, 1'b0, 1'b0, kd, ke, en_ok, en_end, post_idle);
      total++; if (kd !== TIMEOUT || ke !== -1) begin bad++; $display("[TB] FAIL prio_same_edge: got done@%0d err@%0d want done@%0d", kd, ke, TIMEOUT); end
      resp_edges = TIMEOUT + 1;
      do_start();
      drive_bytes(18, 0, cyc, drops);
      wait_outcome(1'b0, 1'b0, 1'b0, kd, ke, en_ok, en_end, post_idle);
      total++; if (ke !== TIMEOUT || kd !== -1) begin bad++; $display("[TB] FAIL prio_one_late: got done@%0d err@%0d want err@%0d", kd, ke, TIMEOUT); end
   endtask

   task automatic test_random();
      int cyc, drops, kd, ke, exp_d, exp_e;
      bit en_ok, en_end, post_idle;
      for (int it = 0; it < 6; it++) begin
         for (int k = 0; k < 18; k++) ref_bytes[k] = 8'($urandom);
         resp_edges = $urandom_range(2, 24);
         exp_d = (resp_edges <= TIMEOUT) ? resp_edges : -1;
         exp_e = (resp_edges <= TIMEOUT) ? -1 : TIMEOUT;
         do_start();
         drive_bytes(18, $urandom_range(0, 60), cyc, drops);
         wait_outcome(1'b1, 1'b0, 1'b0, kd, ke, en_ok, en_end, post_idle);
         total++; if (A_mat !== ref_mat(0)) begin bad++; $display("[TB] FAIL rand%0d_A: got %h want %h", it, A_mat, ref_mat(0)); end
         total++; if (B_mat !== ref_mat(9)) begin bad++; $display("[TB] FAIL rand%0d_B: got %h want %h", it, B_mat, ref_mat(9)); end
         total++; if (kd !== exp_d || ke !== exp_e) begin bad++; $display("[TB] FAIL rand%0d_outcome: got done@%0d err@%0d want done@%0d err@%0d", it, kd, ke, exp_d, exp_e); end
         if (exp_d > 0) begin
            for (int i = 0; i < 9; i++) begin
               total++; if (c_mat[i] !== ref_c(i)) begin bad++; $display("[TB] FAIL rand%0d_C%0d: got %h want %h", it, i, c_mat[i], ref_c(i)); end
            end
         end
      end
   endtask

   task automatic test_reset_mid_load();
      int cyc, drops, kd, ke;
      bit en_ok, en_end, post_idle;
      for (int k = 0; k < 5; k++) ref_bytes[k] = 8'hFF;
      do_start();
      drive_bytes(5, 0, cyc, drops);
      @(posedge clk); #1;
      total++; if (A_mat[0:39] !== 40'hFFFFFFFFFF) begin bad++; $display("[TB] FAIL midload_partial: got %h want ffffffffff", A_mat[0:39]); end
      #1 reset = 1'b1; in_valid = 1'b0;
      #1;
      total++; if (A_mat !== 72'h0) begin bad++; $display("[TB] FAIL midload_A: got %h want 0", A_mat); end
      total++; if (B_mat !== 72'h0) begin bad++; $display("[TB] FAIL midload_B: got %h want 0", B_mat); end
      total++; if (busy !== 1'b0 || in_ready !== 1'b0) begin bad++; $display("[TB] FAIL midload_status: got busy=%b ready=%b want 0/0", busy, in_ready); end
      @(negedge clk); reset = 1'b0;
      for (int k = 0; k < 18; k++) ref_bytes[k] = 8'($urandom);
      resp_edges = 3;
      do_start();
      drive_bytes(18, 30, cyc, drops);
      wait_outcome(1'b0, 1'b0, 1'b0, kd, ke, en_ok, en_end, post_idle);
      total++; if (A_mat !== ref_mat(0)) begin bad++; $display("[TB] FAIL reload_A: got %h want %h", A_mat, ref_mat(0)); end
      total++; if (B_mat !== ref_mat(9)) begin bad++; $display("[TB] FAIL reload_B: got %h want %h", B_mat, ref_mat(9)); end
      total++; if (kd !== 3 || ke !== -1) begin bad++; $display("[TB] FAIL reload_outcome: got done@%0d err@%0d want done@3", kd, ke); end
   endtask

   task automatic test_start_ignored();
      int cyc, drops, kd, ke;
      bit en_ok, en_end, post_idle;
      for (int k = 0; k < 18; k++) ref_bytes[k] = 8'($urandom);
      resp_edges = 6;
      do_start();
      drive_bytes(18, 0, cyc, drops);
      wait_outcome(1'b0, 1'b1, 1'b1, kd, ke, en_ok, en_end, post_idle);
      total++; if (kd !== 6 || ke !== -1) begin bad++; $display("[TB] FAIL ignored_run: got done@%0d err@%0d want done@6", kd, ke); end
      total++; if (!post_idle) begin bad++; $display("[TB] FAIL ignored_done_start: got busy=%b want 0", busy); end
      @(posedge clk); #1;
      total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL ignored_not_queued: got busy=%b want 0", busy); end
      for (int k = 0; k < 9; k++) ref_bytes[k] = 8'h02;
      for (int k = 9; k < 18; k++) ref_bytes[k] = 8'h03;
      resp_edges = 2;
      do_start();
      drive_bytes(18, 0, cyc, drops);
      wait_outcome(1'b0, 1'b0, 1'b0, kd, ke, en_ok, en_end, post_idle);
      total++; if (kd !== 2) begin bad++; $display("[TB] FAIL second_outcome: got done@%0d want done@2", kd); end
      for (int i = 0; i < 9; i++) begin
         total++; if (c_mat[i] !== 8'd18) begin bad++; $display("[TB] FAIL second_C%0d: got %0d want 18", i, c_mat[i]); end
      end
   endtask

   task automatic test_back_to_back();
      int cyc, drops, kd, ke;
      bit en_ok, en_end, post_idle;
      resp_edges = 2;
      @(negedge clk); start = 1'b1;
      @(posedge clk); #1;
      drive_bytes(18, 0, cyc, drops);
      wait_outcome(1'b0, 1'b0, 1'b0, kd, ke, en_ok, en_end, post_idle);
      total++; if (kd !== 2 || !post_idle) begin bad++; $display("[TB] FAIL b2b_first: got done@%0d idle=%b want done@2 idle=1", kd, post_idle); end
      @(posedge clk); #1;
      total++; if (busy !== 1'b1 || in_ready !== 1'b1) begin bad++; $display("[TB] FAIL b2b_restart: got busy=%b ready=%b want 1/1", busy, in_ready); end
      start = 1'b0;
      #2 reset = 1'b1;
      @(negedge clk); reset = 1'b0;
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      test_reset();
      test_identity();
      test_stall();
      test_timeout();
      test_priority();
      test_random();
      test_reset_mid_load();
      test_start_ignored();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
